// File: rtl/conv_pool_pkg.sv
// rtl/conv_pool_pkg.sv - shared defaults and pairing state type for the 2x2 max-pool row block
package conv_pool_pkg;
   localparam int DATA_W_DEF       = 32;
   localparam int IN_COLS_DEF      = 6;
   localparam int ROWS_PER_MAP_DEF = 6;
   localparam int OUT_COLS         = IN_COLS_DEF / 2;

   typedef enum logic {
      ST_EVEN = 1'b0,
      ST_ODD  = 1'b1
   } pool_state_t;
endpackage

// File: rtl/pool_max2.sv
// rtl/pool_max2.sv - combinational signed two-input max, no width growth
module pool_max2 #(
   parameter int DATA_W = 32
) (
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [DATA_W-1:0] y
);
   assign y = (a > b) ? a : b;
endmodule

// File: rtl/pool_max_2x2_row.sv
// rtl/pool_max_2x2_row.sv - pairs conv rows and emits a 2x2 max-pooled row two stages later
// Define POOL_RELU_EN to clamp negative pooled outputs to zero.
module pool_max_2x2_row
   import conv_pool_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int IN_COLS      = IN_COLS_DEF,
   parameter int ROWS_PER_MAP = ROWS_PER_MAP_DEF
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            row_valid,
   input  logic [1:0]                      feature_idx,
   input  logic [IN_COLS*DATA_W-1:0]       data_in,
   output logic                            pool_valid,
   output logic [1:0]                      pool_idx,
   output logic                            pool_last,
   output logic [(IN_COLS/2)*DATA_W-1:0]   data_out,
   output logic                            pair_err
);
   localparam int N_OUT = IN_COLS / 2;
   localparam int CNT_W = (ROWS_PER_MAP > 1) ? $clog2(ROWS_PER_MAP) : 1;

   pool_state_t               state, state_nxt;
   logic [IN_COLS*DATA_W-1:0] row_buf;
   logic [1:0]                buf_idx;
   logic [CNT_W-1:0]          row_cnt, row_cnt_nxt;
   logic                      load_buf, launch, mismatch, last_pair;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_EVEN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      row_cnt_nxt = row_cnt;
      load_buf    = 1'b0;
      launch      = 1'b0;
      mismatch    = 1'b0;
      last_pair   = 1'b0;
      if (row_valid) begin
         case (state)
            ST_EVEN: begin
               load_buf    = 1'b1;
               row_cnt_nxt = row_cnt + CNT_W'(1);
               state_nxt   = ST_ODD;
            end
            ST_ODD: begin
               if (feature_idx == buf_idx) begin
                  launch      = 1'b1;
                  last_pair   = (row_cnt == CNT_W'(ROWS_PER_MAP - 1));
                  row_cnt_nxt = last_pair ? '0 : row_cnt + CNT_W'(1);
                  state_nxt   = ST_EVEN;
               end else begin
                  // orphaned first row is dropped; the new row restarts the pair
                  mismatch    = 1'b1;
                  load_buf    = 1'b1;
                  row_cnt_nxt = CNT_W'(1);
               end
            end
            default: state_nxt = ST_EVEN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_buf  <= '0;
         buf_idx  <= '0;
         row_cnt  <= '0;
         pair_err <= 1'b0;
      end else begin
         if (load_buf) begin
            row_buf <= data_in;
            buf_idx <= feature_idx;
         end
         row_cnt  <= row_cnt_nxt;
         pair_err <= mismatch;
      end
   end

   // stage 1: vertical max, column by column
   logic [IN_COLS*DATA_W-1:0] vmax, s1_row;
   logic                      s1_valid, s1_last;
   logic [1:0]                s1_idx;

   for (genvar c = 0; c < IN_COLS; c++) begin : g_vmax
      pool_max2 #(.DATA_W(DATA_W)) u_vmax (
         .a (row_buf[c*DATA_W +: DATA_W]),
         .b (data_in[c*DATA_W +: DATA_W]),
         .y (vmax[c*DATA_W +: DATA_W])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_idx   <= '0;
         s1_row   <= '0;
      end else begin
         s1_valid <= launch;
         if (launch) begin
            s1_row  <= vmax;
            s1_idx  <= buf_idx;
            s1_last <= last_pair;
         end
      end
   end

   // stage 2: output slot s pools s1 slots 2s+1 and 2s (columns 2k and 2k+1)
   logic [N_OUT*DATA_W-1:0] hmax_raw, hmax;

   for (genvar s = 0; s < N_OUT; s++) begin : g_hmax
      pool_max2 #(.DATA_W(DATA_W)) u_hmax (
         .a (s1_row[(2*s+1)*DATA_W +: DATA_W]),
         .b (s1_row[(2*s)*DATA_W +: DATA_W]),
         .y (hmax_raw[s*DATA_W +: DATA_W])
      );
`ifdef POOL_RELU_EN
      assign hmax[s*DATA_W +: DATA_W] = hmax_raw[s*DATA_W + DATA_W - 1] ? '0
                                      : hmax_raw[s*DATA_W +: DATA_W];
`else
      assign hmax[s*DATA_W +: DATA_W] = hmax_raw[s*DATA_W +: DATA_W];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pool_valid <= 1'b0;
         pool_last  <= 1'b0;
         pool_idx   <= '0;
         data_out   <= '0;
      end else begin
         pool_valid <= s1_valid;
         pool_last  <= s1_valid & s1_last;
         if (s1_valid) begin
            data_out <= hmax;
            pool_idx <= s1_idx;
         end
      end
   end
endmodule

// File: tb/tb_pool_max_2x2_row.sv
// tb/tb_pool_max_2x2_row.sv - scoreboard bench for pool_max_2x2_row with a row-pair reference model
module tb_pool_max_2x2_row;
   import conv_pool_pkg::*;

   localparam int W  = DATA_W_DEF;
   localparam int NC = IN_COLS_DEF;
   localparam int NR = ROWS_PER_MAP_DEF;
   localparam int NO = OUT_COLS;

   typedef int row_t [NC];
   typedef struct {
      logic [NO*W-1:0] data;
      logic [1:0]      idx;
      logic            last;
      int              cyc;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              row_valid = 1'b0;
   logic [1:0]        feature_idx = '0;
   logic [NC*W-1:0]   data_in = '0;
   logic              pool_valid, pool_last, pair_err;
   logic [1:0]        pool_idx;
   logic [NO*W-1:0]   data_out;

   pool_max_2x2_row dut (
      .clk(clk), .rst(rst), .row_valid(row_valid), .feature_idx(feature_idx),
      .data_in(data_in), .pool_valid(pool_valid), .pool_idx(pool_idx),
      .pool_last(pool_last), .data_out(data_out), .pair_err(pair_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t            sb_q[$];
   int              err_q[$];
   int              checks = 0;
   int              errors = 0;
   row_t            m_buf;
   logic [1:0]      m_idx = '0;
   bit              m_have = 0;
   int              m_rows = 0;
   logic [NO*W-1:0] exp_hold = '0;

   task automatic chk(input string name, input logic [NO*W-1:0] act, input logic [NO*W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // reference: a pair of same-map rows yields, per output k, the max of the 2x2 block
   task automatic send_row(input row_t v, input logic [1:0] idx);
      exp_t e;
      int   m;
      @(negedge clk);
      for (int c = 0; c < NC; c++) data_in[(NC-1-c)*W +: W] = v[c];
      row_valid   = 1'b1;
      feature_idx = idx;
      if (!m_have) begin
         m_buf = v; m_idx = idx; m_have = 1; m_rows++;
      end else if (idx == m_idx) begin
         for (int k = 0; k < NO; k++) begin
            m = m_buf[2*k];
            if (v[2*k]       > m) m = v[2*k];
            if (m_buf[2*k+1] > m) m = m_buf[2*k+1];
            if (v[2*k+1]     > m) m = v[2*k+1];
`ifdef POOL_RELU_EN
            if (m < 0) m = 0;
`endif
            e.data[(NO-1-k)*W +: W] = m;
         end
         e.idx  = idx;
         e.last = (m_rows + 1 == NR);
         e.cyc  = cyc + 2;
         sb_q.push_back(e);
         m_rows = (m_rows + 1) % NR;
         m_have = 0;
      end else begin
         m_buf = v; m_idx = idx; m_rows = 1;
         err_q.push_back(cyc + 1);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         row_valid = 1'b0;
      end
   endtask

   task automatic do_reset(input bit with_row);
      @(negedge clk);
      rst = 1'b1;
      row_valid = with_row;
      feature_idx = 2'd1;
      data_in = {NC{32'h0000_0007}};
      sb_q.delete();
      err_q.delete();
      m_have = 0;
      m_rows = 0;
      @(negedge clk);
      rst = 1'b0;
      row_valid = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            chk("rst_pool_valid", pool_valid, 0);
            chk("rst_pool_last", pool_last, 0);
            chk("rst_pair_err", pair_err, 0);
            chk("rst_pool_idx", pool_idx, 0);
            chk("rst_data_out", data_out, 0);
            exp_hold = '0;
         end else begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
               chk("missing_pool_valid", 0, 1);
               void'(sb_q.pop_front());
            end
            while (err_q.size() > 0 && err_q[0] < cyc) begin
               chk("missing_pair_err", 0, 1);
               void'(err_q.pop_front());
            end
            if (pool_valid) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_pool_valid", 1, 0);
                  exp_hold = data_out;
               end else begin
                  e = sb_q.pop_front();
                  chk("pool_latency", cyc, e.cyc);
                  chk("data_out", data_out, e.data);
                  chk("pool_idx", pool_idx, e.idx);
                  chk("pool_last", pool_last, e.last);
                  exp_hold = e.data;
               end
            end else begin
               chk("data_out_hold", data_out, exp_hold);
            end
            if (pair_err) begin
               if (err_q.size() == 0) chk("unexpected_pair_err", 1, 0);
               else chk("pair_err_cycle", cyc, err_q.pop_front());
            end
         end
      end
   end

   initial begin : stim
      row_t a, b;
      logic [1:0] idx;
      int waited;
      do_reset(0);

      a = '{1, 2, 3, 4, 5, 6};       b = '{6, 5, 4, 3, 2, 1};
      send_row(a, 2'd0); send_row(b, 2'd0); idle(4);

      a = '{-5, -3, -8, -1, -2, -9}; b = '{-4, -7, -6, -6, -9, -2};
      send_row(a, 2'd0); send_row(b, 2'd0); idle(4);

      do_reset(0);
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < NC; c++) a[c] = int'($urandom_range(0, 200)) - 100;
         send_row(a, 2'd2);
      end
      idle(4);

      for (int c = 0; c < NC; c++) a[c] = int'($urandom);
      send_row(a, 2'd1);
      for (int c = 0; c < NC; c++) a[c] = int'($urandom);
      send_row(a, 2'd3);
      idle(3);
      for (int c = 0; c < NC; c++) a[c] = int'($urandom);
      send_row(a, 2'd3);
      idle(4);

      a = '{9, 9, 9, 9, 9, 9};
      send_row(a, 2'd0); send_row(a, 2'd0);
      do_reset(0);
      do_reset(1);
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < NC; c++) a[c] = int'($urandom_range(0, 50)) - 25;
         send_row(a, 2'd1);
      end
      idle(4);

      for (int i = 0; i < 300; i++) begin
         if (m_have && $urandom_range(0, 9) < 8) idx = m_idx;
         else idx = 2'($urandom_range(0, 3));
         for (int c = 0; c < NC; c++)
            a[c] = ($urandom_range(0, 1) == 0) ? int'($urandom) : int'($urandom_range(0, 20)) - 10;
         send_row(a, idx);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(2);

      waited = 0;
      while ((sb_q.size() > 0 || err_q.size() > 0) && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (sb_q.size() > 0 || err_q.size() > 0) chk("drain_timeout", 1, 0);
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
